// File: rtl/mem_access_unit_pkg.sv
// Shared load/store definitions: funct3 access encodings, FSM states and
// the legality check on the requested access type.
package mem_access_unit_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  function automatic logic size_illegal(input logic we, input logic [2:0] size);
    logic bad;
    if (we) bad = (size != F3_SB) && (size != F3_SH) && (size != F3_SW);
    else    bad = (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: misalignment check, store-lane merge into the old
// RAM word and sign/zero-extended load extraction.
module lsu_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic        misaligned_o,
  output logic [31:0] store_word_o,
  output logic [31:0] load_word_o
);

  logic [31:0] shifted;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign byte_sh   = {addr_lo_i, 3'b000};
  assign half_sh   = {addr_lo_i[1], 4'b0000};
  assign shifted   = word_i >> byte_sh;
  assign byte_mask = 32'h0000_00FF << byte_sh;
  assign half_mask = 32'h0000_FFFF << half_sh;

  always_comb begin
    misaligned_o = 1'b0;
    store_word_o = wdata_i;
    load_word_o  = word_i;
    case (size_i[1:0])
      2'b00: begin
        store_word_o = (word_i & ~byte_mask) | ({24'd0, wdata_i[7:0]} << byte_sh);
        load_word_o  = {{24{shifted[7] & ~size_i[2]}}, shifted[7:0]};
      end
      2'b01: begin
        misaligned_o = addr_lo_i[0];
        store_word_o = (word_i & ~half_mask) | ({16'd0, wdata_i[15:0]} << half_sh);
        load_word_o  = {{16{shifted[15] & ~size_i[2]}}, shifted[15:0]};
      end
      2'b10: misaligned_o = (addr_lo_i != 2'b00);
      default: misaligned_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: one request at a time, aligned word RAM accesses,
// read-modify-write for sub-word stores.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_e            state_q;
  logic              we_q;
  logic              err_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] merged_q;
  logic [DATA_W-1:0] rdata_q;

  logic              idle;
  logic [2:0]        al_size;
  logic [1:0]        al_lo;
  logic              al_misaligned;
  logic [31:0]       al_store;
  logic [31:0]       al_load;

  assign idle = (state_q == ST_IDLE);

  // The aligner checks the incoming request while idle and the latched one afterwards.
  assign al_size = idle ? size_i : size_q;
  assign al_lo   = idle ? addr_i[1:0] : addr_q[1:0];

  lsu_align u_align (
    .size_i       (al_size),
    .addr_lo_i    (al_lo),
    .word_i       (mem_data_i),
    .wdata_i      (wdata_q),
    .misaligned_o (al_misaligned),
    .store_word_o (al_store),
    .load_word_o  (al_load)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      rdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            if (size_illegal(we_i, size_i) || al_misaligned) begin
              err_q   <= 1'b1;
              state_q <= ST_DONE;
            end else if (we_i && size_i == F3_SW) begin
              err_q    <= 1'b0;
              merged_q <= wdata_i;
              state_q  <= ST_WRITE;
            end else begin
              err_q   <= 1'b0;
              state_q <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (we_q) begin
            merged_q <= al_store;
            state_q  <= ST_WRITE;
          end else begin
            rdata_q <= al_load;
            state_q <= ST_DONE;
          end
        end
        ST_WRITE: state_q <= ST_DONE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o    = rstn && idle;
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = done_o && err_q;
  assign rdata_o    = rdata_q;
  // Reset gates the strobe immediately so an abort in WRITE never commits.
  assign mem_we_o   = rstn && (state_q == ST_WRITE);
  assign mem_addr_o = idle ? '0 : {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_data_o = merged_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed vector bench for mem_access_unit with a small behavioural RAM.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [2:0]  size_i = 3'd0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        ready_o, done_o, err_o, mem_we_o;
  logic [31:0] rdata_o, mem_addr_o, mem_data_o, mem_data_i;

  logic [31:0] ram [0:63];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .rdata_o    (rdata_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i)
  );

  assign mem_data_i = ram[mem_addr_o[7:2]];

  always @(posedge clk) begin
    if (poke_en) ram[poke_idx] <= poke_val;
    else if (mem_we_o) ram[mem_addr_o[7:2]] <= mem_data_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] byte_addr, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = byte_addr[7:2]; poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          we_cyc;   // cycle of the single write strobe, 0 = none
    logic [31:0] ram_exp;  // expected RAM word afterwards at the aligned address
  } vec_t;

  vec_t vecs [16];

  // Issue one request and observe it cycle by cycle after the accepting edge.
  task automatic run_vec(input int idx, input vec_t v);
    int lat = 99;
    int we_first = 0;
    int we_count = 0;
    logic err_seen = 1'b0;
    logic [31:0] addr_seen = '0;
    logic ready_at_done = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d ready_before", idx), {31'd0, ready_o}, 32'd1);
    req_i = 1'b1; we_i = v.we; size_i = v.size; addr_i = v.addr; wdata_i = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_i = 1'b0;
      if (mem_we_o) begin
        we_count++;
        if (we_first == 0) we_first = k;
      end
      if (done_o) begin
        lat = k; err_seen = err_o; addr_seen = mem_addr_o; ready_at_done = ready_o;
        break;
      end
    end
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d err", idx), {31'd0, err_seen}, {31'd0, v.err});
    check($sformatf("v%0d rdata", idx), rdata_o, v.rdata);
    check($sformatf("v%0d we_cycle", idx), we_first, v.we_cyc);
    check($sformatf("v%0d we_count", idx), we_count, (v.we_cyc != 0) ? 1 : 0);
    check($sformatf("v%0d done_addr", idx), addr_seen, v.addr & 32'hFFFF_FFFC);
    check($sformatf("v%0d ready_in_done", idx), {31'd0, ready_at_done}, 32'd0);
    check($sformatf("v%0d ram", idx), ram[v.addr[7:2]], v.ram_exp);
    $display("vec %0d we=%0d size=%03b addr=0x%02h lat=%0d err=%0d rdata=0x%08h ram=0x%08h",
             idx, v.we, v.size, v.addr[7:0], lat, err_seen, rdata_o, ram[v.addr[7:2]]);
  endtask

  initial begin
    int done_cnt;
    logic we_seen;

    //            we    size    addr    wdata          lat err rdata          we ram
    vecs[0]  = '{1'b0, 3'b000, 32'h13, 32'h0,          2, 0, 32'hFFFF_FF80, 0, 32'h80FF_7F01};
    vecs[1]  = '{1'b0, 3'b101, 32'h12, 32'h0,          2, 0, 32'h0000_80FF, 0, 32'h80FF_7F01};
    vecs[2]  = '{1'b0, 3'b001, 32'h12, 32'h0,          2, 0, 32'hFFFF_80FF, 0, 32'h80FF_7F01};
    vecs[3]  = '{1'b0, 3'b100, 32'h10, 32'h0,          2, 0, 32'h0000_0001, 0, 32'h80FF_7F01};
    vecs[4]  = '{1'b0, 3'b000, 32'h11, 32'h0,          2, 0, 32'h0000_007F, 0, 32'h80FF_7F01};
    vecs[5]  = '{1'b0, 3'b010, 32'h10, 32'h0,          2, 0, 32'h80FF_7F01, 0, 32'h80FF_7F01};
    vecs[6]  = '{1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB,  3, 0, 32'h80FF_7F01, 2, 32'h1122_AB44};
    vecs[7]  = '{1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF,  2, 0, 32'h80FF_7F01, 1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 3'b010, 32'h22, 32'h0,          1, 1, 32'h80FF_7F01, 0, 32'h1122_AB44};
    vecs[9]  = '{1'b1, 3'b001, 32'h23, 32'h0000_1234,  1, 1, 32'h80FF_7F01, 0, 32'h1122_AB44};
    vecs[10] = '{1'b0, 3'b011, 32'h10, 32'h0,          1, 1, 32'h80FF_7F01, 0, 32'h80FF_7F01};
    vecs[11] = '{1'b1, 3'b100, 32'h20, 32'h0000_0077,  1, 1, 32'h80FF_7F01, 0, 32'h1122_AB44};
    vecs[12] = '{1'b1, 3'b001, 32'h22, 32'hAAAA_5566,  3, 0, 32'h80FF_7F01, 2, 32'h5566_AB44};
    vecs[13] = '{1'b0, 3'b001, 32'h22, 32'h0,          2, 0, 32'h0000_5566, 0, 32'h5566_AB44};
    vecs[14] = '{1'b0, 3'b000, 32'h27, 32'h0,          2, 0, 32'hFFFF_FFDE, 0, 32'hDEAD_BEEF};
    vecs[15] = '{1'b0, 3'b101, 32'h24, 32'h0,          2, 0, 32'h0000_BEEF, 0, 32'hDEAD_BEEF};

    for (int i = 0; i < 64; i++) begin
      poke(32'(i * 4), 32'h0);
    end
    poke(32'h10, 32'h80FF_7F01);
    poke(32'h20, 32'h1122_3344);
    poke(32'h30, 32'h9988_7766);

    // Reset state while rstn is held low.
    @(negedge clk);
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, ready_o}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      run_vec(i, vecs[i]);
    end

    // Reset asserted during the WRITE cycle of an SB must drop the strobe and the done.
    @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; size_i = 3'b000; addr_i = 32'h31; wdata_i = 32'h0000_00CC;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("abort_in_write_state", {31'd0, mem_we_o}, 32'd1);
    rstn = 1'b0;
    #1;
    check("abort_we_forced_low", {31'd0, mem_we_o}, 32'd0);
    check("abort_ready_low", {31'd0, ready_o}, 32'd0);
    done_cnt = 0;
    we_seen = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      if (mem_we_o) we_seen = 1'b1;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_no_write", {31'd0, we_seen}, 32'd0);
    check("abort_ram_unchanged", ram[6'h0C], 32'h9988_7766);
    check("abort_ready_after", {31'd0, ready_o}, 32'd1);
    check("abort_rdata_cleared", rdata_o, 32'd0);
    $display("abort sb addr=0x31 ram=0x%08h ready=%0d", ram[6'h0C], ready_o);

    // The unit must still work normally after the aborted request.
    run_vec(16, '{1'b0, 3'b000, 32'h12, 32'h0, 2, 0, 32'hFFFF_FFFF, 0, 32'h80FF_7F01});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the core's memory stage and the word-wide data RAM. It accepts one byte, halfword or word request at a time and performs aligned word reads. Sub-word stores use a read-modify-write, and load data is sign- or zero-extended. It is the master end of the RAM's single-port interface: write strobe, word address, write data and combinational read data.

## Interface
- ADDR_W, 32, byte-address width, equal to the `MemAddrBus` width.
- DATA_W, 32, RAM word width, equal to the `MemBus` width. Only 32 is supported.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- req_i  in  1  request valid. Sampled only while ready_o=1.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  3  RISC-V funct3 access type.
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data, taken from the LSBs for sub-word stores.
- ready_o  out  1  unit idle, can accept a request.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: misaligned access or illegal size.
- rdata_o  out  DATA_W  extended load data. Valid with done_o and held until the next accept.
- mem_we_o  out  1  RAM write strobe.
- mem_addr_o  out  ADDR_W  RAM byte address, always word-aligned (bits [1:0]=0).
- mem_data_o  out  DATA_W  RAM write data.
- mem_data_i  in  DATA_W  RAM read data, combinational from mem_addr_o.

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- IDLE:
  - ready_o=1.
  - On req_i, latch we, size, addr and wdata.
  - Illegal size or misaligned access → DONE with the err flag set.
  - SW (store word) → WRITE.
  - All other accesses → ACCESS.
- ACCESS:
  - mem_addr_o={addr[31:2],2'b00}, mem_we_o=0, mem_data_i sampled.
  - Load: extract the lane, extend it, register it into rdata_o, → DONE.
  - SB/SH: form the merged word (old word with the addressed lane replaced), → WRITE.
- WRITE:
  - mem_we_o=1, mem_addr_o=aligned address, mem_data_o=merged word (SW: wdata unchanged).
  - → DONE.
- DONE: done_o=1, err_o=err flag, → IDLE.
- Access types:
  - Loads: LB=000 (sign-extend), LH=001 (sign-extend), LW=010, LBU=100 (zero-extend), LHU=101 (zero-extend).
  - Stores: SB=000, SH=001, SW=010.
  - Illegal sizes: loads 011/110/111; stores any value other than 000/001/010.
- Alignment rules:
  - Halfword access requires addr[0]=0.
  - Word access requires addr[1:0]=0.
  - Byte access is always aligned.
- Lane select:
  - Byte: wdata[7:0] into bits [8*addr[1:0] +: 8].
  - Halfword: wdata[15:0] into bits [16*addr[1] +: 16].
- An errored request issues no RAM write. rdata_o keeps its previous value.
- mem_we_o is 0 in every state except WRITE.

## Timing
- Reset (rstn=0 at an edge):
  - State → IDLE.
  - rdata_o=0, err flag=0, latched request fields=0.
  - mem_we_o is forced to 0 combinationally while rstn=0.
  - ready_o=0 while rstn=0, then 1 in the cycle after reset is released.
- Reset mid-operation aborts the operation:
  - A reset in WRITE suppresses the write.
  - No done_o is produced for the aborted request.
- Latency from the accepting edge (cycle 0) to done_o high:
  - Load: 2 cycles.
  - SB/SH: 3 cycles.
  - SW: 2 cycles.
  - Error: 1 cycle.
- The RAM commits the write on the clock edge that ends the WRITE cycle, so the data is visible to the RAM read port in the DONE cycle.
- ready_o=0 from ACCESS through DONE. req_i is ignored while ready_o=0.
- A new request can be accepted in the cycle after DONE, so back-to-back loads complete every 3 cycles.
- mem_addr_o holds the aligned latched address in ACCESS, WRITE and DONE, and is 0 in IDLE.

## Structure
- Funct3 encodings (LB…LHU, SB/SH/SW) and the state encodings go in the shared core `define.v`, next to `MemAddrBus`, `MemBus` and `MemNum`.
- One sub-module is natural: `lsu_align`, purely combinational. It computes the misaligned flag, the lane-merged store word and the extended load value from size, addr[1:0], the RAM word and wdata.
- The FSM and registers stay in mem_access_unit.

## Test plan
- LB sign: RAM[0x10]=0x80FF_7F01, load LB at addr 0x13 → done_o at +2, rdata_o=0xFFFF_FF80, err_o=0.
- LHU/LH: same word, LHU at 0x12 → 0x0000_80FF; LH at 0x12 → 0xFFFF_80FF.
- SB merge: RAM[0x20]=0x1122_3344, SB wdata=0xAB at 0x21 → mem_we_o high exactly 1 cycle at +2, RAM[0x20]=0x1122_AB44, done_o at +3.
- SW direct: SW 0xDEAD_BEEF at 0x24 → no ACCESS cycle, mem_we_o at +1, done_o at +2, RAM word=0xDEAD_BEEF.
- Errors: LW at 0x22, SH at 0x23, and a load with size 011 → each gives done_o=1, err_o=1 at +1, never asserts mem_we_o, and leaves rdata_o unchanged.
- Reset in WRITE of an SB → mem_we_o=0, RAM unchanged, no done_o, ready_o=1 in the cycle after rstn returns to 1.
